counter_sequencer: RTL



---
 rtl/counter_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: clear/run/done sequencer for an external up-counter.
// Define COUNTER_SEQ_WATCHDOG_EN to add the RUN-length watchdog on err.
module counter_sequencer #(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic [7:0]       lap_count,
  output logic             err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] tgt_q;
  logic             cont_q;
  logic [PW-1:0]    presc;
  logic             tick;
  logic             match;
  logic             accept;
  logic             lap_inc;
  logic             wd_exp;

  assign tick   = (presc == PW'(PRESCALE - 1));
  assign match  = (cnt_val == tgt_q);
  assign accept = (state == IDLE) && start && !stop;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    lap_inc = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_n = CLEAR;
      end
      CLEAR: begin
        cnt_clr = 1'b1;
        state_n = stop ? IDLE : RUN;
      end
      RUN: begin
        cnt_en = tick && !match && !stop;
        if (stop) begin
          state_n = IDLE;
        end else if (match) begin
          if (cont_q) begin
            state_n = CLEAR;
            lap_inc = 1'b1;
          end else begin
            state_n = DONE;
          end
        end else if (wd_exp) begin
          state_n = IDLE;
        end
      end
      DONE: begin
        // an abort landing on the completion cycle suppresses the pulse
        done    = !stop;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q     <= '0;
      cont_q    <= 1'b0;
      lap_count <= 8'd0;
      presc     <= '0;
    end else begin
      if (accept) begin
        tgt_q     <= target;
        cont_q    <= continuous;
        lap_count <= 8'd0;
      end else if (lap_inc && lap_count != 8'hFF) begin
        lap_count <= lap_count + 8'd1;
      end
      if (state != RUN || tick) presc <= '0;
      else                      presc <= presc + 1'b1;
    end
  end

`ifdef COUNTER_SEQ_WATCHDOG_EN
  localparam int WD_LIMIT = (2 ** WIDTH) * PRESCALE + 2;
  localparam int WW       = $clog2(WD_LIMIT + 1);

  logic [WW-1:0] wd_cnt;

  // wd_cnt holds the number of RUN cycles already completed
  assign wd_exp = (wd_cnt == WW'(WD_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != RUN) wd_cnt <= '0;
      else              wd_cnt <= wd_cnt + 1'b1;
      if (accept)
        err <= 1'b0;
      else if (state == RUN && !stop && !match && wd_exp)
        err <= 1'b1;
    end
  end
`else
  assign wd_exp = 1'b0;
  assign err    = 1'b0;
`endif

endmodule
